// File: rtl/fc_act_loader.sv
// ============================================================================
// fc_act_loader : streams WIDTH-bit activations into a parallel IN-entry vector
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_act_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err_len,
    output logic [15:0]      frame_cnt
);

    localparam int              IDXW     = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(IN - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_nx;
    logic            accept;
    logic            wr_en;
    logic            err_nx;
    logic            handoff;

    // s_ready is registered and only ever high in FILL
    assign accept = s_valid & s_ready & (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wr_en    = 1'b0;
        err_nx   = 1'b0;
        handoff  = 1'b0;
        if (state == FILL) begin
            if (accept) begin
                wr_en = 1'b1;
                if (idx == LAST_IDX) begin
                    // a full-length frame is delivered even when s_last is missing
                    state_nx = FULL;
                    idx_nx   = '0;
                    err_nx   = ~s_last;
                end else if (s_last) begin
                    idx_nx = '0;
                    err_nx = 1'b1;
                end else begin
                    idx_nx = idx + IDXW'(1);
                end
            end
        end else begin
            if (x_ready) begin
                state_nx = FILL;
                handoff  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            x_valid   <= 1'b0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < IN; i++) begin
                x[i] <= '0;
            end
        end else begin
            s_ready   <= (state_nx == FILL);
            x_valid   <= (state_nx == FULL);
            err_len   <= err_nx;
            frame_cnt <= frame_cnt + 16'(handoff);
            if (wr_en) begin
                x[idx] <= s_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_act_loader.sv
// ============================================================================
// tb_fc_act_loader : randomized self-checking bench with a frame-level model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_act_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             err_len;
    logic [15:0]      frame_cnt;

    fc_act_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .err_len   (err_len),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frames are collected as whole lists of beats
    beat_t            src_q[$];
    logic [WIDTH-1:0] frame_q[$];
    logic [WIDTH-1:0] m_x [0:IN-1];
    bit               m_rdy;
    bit               m_full;
    bit               m_err;
    logic [15:0]      m_frames;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_x(input string tag);
        for (int i = 0; i < IN; i++) begin
            check($sformatf("%s x[%0d]", tag, i), 32'(x[i]), 32'(m_x[i]));
        end
    endtask

    task automatic model_reset();
        m_rdy    = 1'b0;
        m_full   = 1'b0;
        m_err    = 1'b0;
        m_frames = '0;
        frame_q.delete();
        for (int i = 0; i < IN; i++) m_x[i] = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " s_ready"},   32'(s_ready),   32'(m_rdy));
        check({tag, " x_valid"},   32'(x_valid),   32'(m_full));
        check({tag, " err_len"},   32'(err_len),   32'(m_err));
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
    endtask

    // mode 0: data=i, 1: data=val, 2: random
    task automatic push_frame(input int n, input int last_at, input int mode, input logic [WIDTH-1:0] val);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = (mode == 0) ? WIDTH'(i) : (mode == 1) ? val : WIDTH'($urandom);
            b.l = (i == last_at);
            src_q.push_back(b);
        end
    endtask

    task automatic cycle(input bit gaps, input bit xr);
        bit prev_full;
        bit hand;
        prev_full = m_full;
        hand      = 1'b0;
        s_valid   = (src_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
        if (s_valid) begin
            s_data = src_q[0].d;
            s_last = src_q[0].l;
        end else begin
            s_data = WIDTH'($urandom);
            s_last = 1'($urandom);
        end
        x_ready = xr;
        @(posedge clk);
        m_err = 1'b0;
        if (!m_full && m_rdy && s_valid) begin
            void'(src_q.pop_front());
            frame_q.push_back(s_data);
            if (frame_q.size() == IN) begin
                for (int i = 0; i < IN; i++) m_x[i] = frame_q[i];
                m_full = 1'b1;
                m_err  = !s_last;
                frame_q.delete();
            end else if (s_last) begin
                m_err = 1'b1;
                frame_q.delete();
            end
        end else if (m_full && xr) begin
            m_full   = 1'b0;
            m_frames = m_frames + 16'd1;
            hand     = 1'b1;
        end
        m_rdy = !m_full;
        #1;
        check_outputs("cyc");
        if ((m_full && !prev_full) || hand) check_x(hand ? "handoff" : "frame");
    endtask

    task automatic run_until_full(input bit gaps, input int budget);
        int n = 0;
        while (!m_full && n < budget) begin
            cycle(gaps, 1'($urandom));
            n++;
        end
        if (!m_full) check("timeout waiting for frame", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        src_q.delete();
        model_reset();
        #1;
        check_outputs("reset");
        check_x("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        x_ready = 1'b0;
        model_reset();
        apply_reset();

        // nominal frame, consumer not ready
        push_frame(IN, IN - 1, 0, '0);
        run_until_full(1'b0, 400);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        // handoff
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // early last then a good constant frame
        push_frame(11, 10, 2, '0);
        push_frame(IN, IN - 1, 1, 8'hA5);
        run_until_full(1'b0, 400);
        cycle(1'b0, 1'b1);

        // missing last
        push_frame(IN, -1, 2, '0);
        run_until_full(1'b0, 400);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // backpressure, gaps and beats presented while full
        push_frame(IN, IN - 1, 2, '0);
        push_frame(IN, IN - 1, 2, '0);
        push_frame(IN, IN - 1, 2, '0);
        for (int n = 0; n < 3000 && (src_q.size() > 0 || m_full); n++) begin
            cycle(1'b1, $urandom_range(0, 5) == 0);
        end
        if (src_q.size() > 0 || m_full) check("timeout draining frames", 32'd0, 32'd1);

        // reset mid-frame
        push_frame(IN, IN - 1, 2, '0);
        for (int n = 0; n < 200 && frame_q.size() < 50; n++) cycle(1'b0, 1'b0);
        check("beats before reset", 32'(frame_q.size()), 32'd50);
        apply_reset();
        cycle(1'b0, 1'b0);
        push_frame(IN, IN - 1, 2, '0);
        run_until_full(1'b0, 400);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
